c_rr_mux_reg: RTL
=================

Name: c_rr_mux_reg

Overview:
- Parametrised successor to the team's fixed 8:1 select mux.
- Merges CHANNELS valid/ready input streams onto one registered output stream.
- Selection is internal: round-robin arbitration, or fixed priority by parameter. No external select.
- Optional packet locking holds a grant until the packet's last beat. Used wherever several producers share one bus, e.g. the writeback/result path.

Parameters:
- BITS, 32: data width per channel.
- CHANNELS, 8: number of input channels, range 2..16.
- SEL_W, clog2(CHANNELS): width of the out_sel index.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.
- PACKET, 0: 1 = a grant is locked from the first beat until the beat with in_last set.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  CHANNELS  per-channel data valid.
- in_data  in  CHANNELS*BITS  flattened data; channel i occupies bits [i*BITS +: BITS].
- in_last  in  CHANNELS  per-channel last beat of packet; ignored when PACKET=0.
- in_ready  out  CHANNELS  per-channel accept, combinational.
- out_valid  out  1  registered output valid.
- out_data  out  BITS  registered output data.
- out_last  out  1  registered last flag; forced to 1 when PACKET=0.
- out_sel  out  SEL_W  index of the channel that produced the current output beat.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset, synchronous and active-high, on the next clk edge:
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Round-robin pointer ptr=0, lock=0, locked_ch=0.
  - rst dominates every other input in the same cycle. Reset mid-packet drops the lock; no beat is replayed.
- Stage enable: adv = ~out_valid | out_ready.
- Grant, combinational:
  - lock=1: grant = locked_ch if in_valid[locked_ch], otherwise no grant. Other channels stall.
  - RR_MODE=1: first i with in_valid[i], scanning ptr, ptr+1, ..., wrapping modulo CHANNELS.
  - RR_MODE=0: lowest index with in_valid[i].
- in_ready[g] = adv & grant_valid & (grant==g). All other in_ready bits are 0.
  - in_ready may depend on in_valid. in_valid must not depend on in_ready.
- Transfer on channel g (in_valid[g] & in_ready[g]):
  - Next edge: out_valid=1, out_data=in_data[g], out_sel=g, out_last = PACKET ? in_last[g] : 1.
- No transfer and out_ready=1: out_valid goes to 0 at the next edge.
- out_valid=1 and out_ready=0: out_data, out_sel and out_last hold stable. No input is accepted.
- Latency is 1 cycle input-to-output. Throughput is 1 beat/cycle with out_ready tied high.
- Pointer update (RR_MODE=1):
  - PACKET=0: after each transfer from g, ptr = (g+1) mod CHANNELS.
  - PACKET=1: ptr updates only on a transfer with in_last set.
  - Wrap: g=CHANNELS-1 gives ptr=0.
- Lock FSM, PACKET=1 only:
  - States are IDLE (lock=0) and LOCKED (lock=1, locked_ch).
  - IDLE to LOCKED on a transfer with in_last=0; locked_ch=g.
  - LOCKED to IDLE on a transfer from locked_ch with in_last=1.
  - A single-beat packet (in_last=1 in IDLE) stays in IDLE.
  - A locked channel deasserting in_valid stalls the merge; the lock is held.
- No valid inputs: no grant, in_ready all 0, ptr unchanged.
- CHANNELS not a power of 2: out_sel values >= CHANNELS never occur. Pointer wrap uses CHANNELS, not 2^SEL_W.

Decomposition:
- Shared package/header c_pkg holds the clog2 constant function and the mode encodings RR_MODE_FIXED=0 and RR_MODE_RR=1.
- One natural sub-module: c_rr_arbiter (CHANNELS, RR_MODE). Inputs: request vector, ptr, lock, locked_ch. Outputs: one-hot grant, grant index, grant_valid. Purely combinational.
- The parent owns the ptr/lock registers and the output register stage.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_sel=0, in_ready=0 during reset. First grant after reset goes to ch0.
- Round-robin fairness: CHANNELS=8, RR_MODE=1, all in_valid=1, in_data[i]=i, out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles, with out_data equal to out_sel.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data, out_sel and out_last stable; all in_ready=0. Release -> the next beat appears 1 cycle later and nothing is lost or duplicated.
- Fixed priority: RR_MODE=0, in_valid=8'b1010_0100 -> ch2 wins every cycle until in_valid[2]=0, then ch5, then ch7.
- Packet lock: PACKET=1; ch3 sends a 4-beat packet (in_last on beat 4) while ch1 is valid throughout -> beats 3,3,3,3 with out_last only on the 4th, then ch4..7 and ch0 not valid, so ch1 next. A 2-cycle in_valid[3] gap mid-packet -> out_valid drops for those beats and ch1 is still blocked.
- Wrap and odd size: CHANNELS=5, only ch4 and ch0 valid -> alternating 4,0,4,0. out_sel never exceeds 4.

Source files
------------

// File: rtl/c_pkg.sv
// Shared constants and helpers for the c_* merge/arbitration blocks.
// Holds the arbitration mode encodings and a constant clog2 for port sizing.
package c_pkg;

    localparam int RR_MODE_FIXED = 0;
    localparam int RR_MODE_RR    = 1;

    // Never returns less than 1 so single-bit indices stay legal.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/c_rr_arbiter.sv
// Combinational channel arbiter: round-robin from ptr or fixed lowest-index priority,
// with an override that restricts the grant to locked_ch while a packet is in flight.
module c_rr_arbiter import c_pkg::*; #(
    parameter int CHANNELS = 8,
    parameter int RR_MODE  = RR_MODE_RR,
    parameter int SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                lock,
    input  logic [SEL_W-1:0]    locked_ch,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        if (lock) begin
            if (req[locked_ch]) begin
                grant_valid = 1'b1;
                grant_idx   = locked_ch;
            end
        end else begin
            // Wrap at CHANNELS, not 2^SEL_W, so odd channel counts never alias.
            for (int k = 0; k < CHANNELS; k++) begin
                idx = (RR_MODE == RR_MODE_RR) ? int'(ptr) + k : k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!grant_valid && req[idx[SEL_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx[SEL_W-1:0];
                end
            end
        end
        if (grant_valid) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/c_rr_mux_reg.sv
// Merges CHANNELS valid/ready streams onto one registered output stream with
// internal round-robin or fixed-priority selection and optional packet locking.
module c_rr_mux_reg import c_pkg::*; #(
    parameter int BITS     = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = clog2(CHANNELS),
    parameter int RR_MODE  = RR_MODE_RR,
    parameter int PACKET   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      in_valid,
    input  logic [CHANNELS*BITS-1:0] in_data,
    input  logic [CHANNELS-1:0]      in_last,
    output logic [CHANNELS-1:0]      in_ready,
    output logic                     out_valid,
    output logic [BITS-1:0]          out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    typedef enum logic {IDLE, LOCKED} lock_state_t;

    lock_state_t         state_p0;
    logic [SEL_W-1:0]    ptr_p0;
    logic [SEL_W-1:0]    locked_ch_p0;

    logic                vld_p1;
    logic [BITS-1:0]     data_p1;
    logic                last_p1;
    logic [SEL_W-1:0]    sel_p1;

    logic                adv;
    logic                lock;
    logic                xfer;
    logic                gl;
    logic [BITS-1:0]     gdata;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_valid;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] g);
        if (int'(g) == CHANNELS - 1) return '0;
        return g + 1'b1;
    endfunction

    assign lock = (PACKET != 0) && (state_p0 == LOCKED);

    c_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .RR_MODE  (RR_MODE),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr_p0),
        .lock        (lock),
        .locked_ch   (locked_ch_p0),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Stage p0 -> p1: grant selects one input beat into the output register.
    assign adv      = ~vld_p1 | out_ready;
    assign xfer     = adv & grant_valid & ~rst;
    assign in_ready = xfer ? grant : '0;
    assign gdata    = in_data[int'(grant_idx)*BITS +: BITS];
    assign gl       = in_last[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            last_p1      <= 1'b0;
            sel_p1       <= '0;
            ptr_p0       <= '0;
            state_p0     <= IDLE;
            locked_ch_p0 <= '0;
        end else begin
            if (adv) begin
                vld_p1 <= xfer;
                if (xfer) begin
                    data_p1 <= gdata;
                    sel_p1  <= grant_idx;
                    last_p1 <= (PACKET != 0) ? gl : 1'b1;
                end
            end
            if (xfer && RR_MODE == RR_MODE_RR && (PACKET == 0 || gl))
                ptr_p0 <= wrap_inc(grant_idx);
            if (xfer && PACKET != 0) begin
                case (state_p0)
                    IDLE: if (!gl) begin
                        state_p0     <= LOCKED;
                        locked_ch_p0 <= grant_idx;
                    end
                    LOCKED: if (gl) state_p0 <= IDLE;
                    default: state_p0 <= IDLE;
                endcase
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;
    assign out_sel   = sel_p1;

endmodule
